// File: rtl/count_pkg.sv
// Shared definitions for the count_updown_mod counter family: direction codes
// and elaboration-time width helpers.
package count_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic int unsigned clog2(input longint unsigned value);
    for (int unsigned r = 0; r < 64; r++) begin
      if ((64'd1 << r) >= value) return r;
    end
    return 64;
  endfunction

  // True when every value 0..max_count is representable in width bits.
  function automatic bit fits_width(input int unsigned max_count, input int unsigned width);
    return clog2(longint'(max_count) + 1) <= width;
  endfunction

endpackage

// File: rtl/count_updown_mod_bin2bcd.sv
// bin2bcd_dd: combinational double-dabble binary to packed BCD converter,
// digit 0 in bits [3:0].
module bin2bcd_dd #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic [WIDTH-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  logic [WIDTH-1:0]        shift;
  logic [4*BCD_DIGITS-1:0] acc;

  always_comb begin
    shift = bin;
    acc   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // Add-3 correction on every digit before each shift keeps digits decimal.
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
        if (acc[4*d +: 4] > 4'd4) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc   = {acc[4*BCD_DIGITS-2:0], shift[WIDTH-1]};
      shift = shift << 1;
    end
    bcd = acc;
  end

endmodule

// File: rtl/count_updown_mod.sv
// count_updown_mod: modulo-(MAX_COUNT+1) up/down counter with clear, load,
// cascade terminal count and wrap pulse. Define COUNT_BCD_EN to add bcd_out.
module count_updown_mod
  import count_pkg::*;
#(
  parameter int unsigned WIDTH       = 7,
  parameter int unsigned MAX_COUNT   = 99,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned BCD_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    async_reset_n,
  input  logic                    enable,
  input  logic                    up_dn,
  input  logic                    sync_clear,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_value,
  output logic [WIDTH-1:0]        count_out,
  output logic                    tc_out,
  output logic                    wrap_pulse
`ifdef COUNT_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  if (!fits_width(MAX_COUNT, WIDTH)) begin : g_bad_width
    $error("count_updown_mod: MAX_COUNT does not fit in WIDTH bits");
  end
  if (RESET_VALUE > MAX_COUNT) begin : g_bad_reset
    $error("count_updown_mod: RESET_VALUE exceeds MAX_COUNT");
  end
  if (BCD_DIGITS == 0) begin : g_bad_digits
    $error("count_updown_mod: BCD_DIGITS must be at least 1");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VALUE);

  logic             at_max;
  logic             at_zero;
  logic             over_max;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign at_max       = (count_out == MAX_C);
  assign at_zero      = (count_out == '0);
  assign over_max     = (count_out > MAX_C);
  assign load_clamped = (load_value > MAX_C) ? MAX_C : load_value;

  // Combinational so a downstream digit's enable sees it in the same cycle.
  assign tc_out = enable & ~sync_clear & ~load & ((up_dn == DIR_UP) ? at_max : at_zero);

  always_comb begin
    count_next = count_out;
    wrap_next  = 1'b0;
    if (sync_clear) begin
      count_next = RST_C;
    end else if (load) begin
      count_next = load_clamped;
    end else if (enable) begin
      if (up_dn == DIR_UP) begin
        count_next = (at_max || over_max) ? '0 : count_out + WIDTH'(1);
        wrap_next  = at_max;
      end else begin
        count_next = (at_zero || over_max) ? MAX_C : count_out - WIDTH'(1);
        wrap_next  = (up_dn == DIR_DN) && at_zero;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      count_out  <= RST_C;
      wrap_pulse <= 1'b0;
    end else begin
      count_out  <= count_next;
      wrap_pulse <= wrap_next;
    end
  end

`ifdef COUNT_BCD_EN
  bin2bcd_dd #(
    .WIDTH      (WIDTH),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bcd (
    .bin (count_out),
    .bcd (bcd_out)
  );
`endif

endmodule

// File: tb/tb_count_updown_mod.sv
// Self-checking bench for count_updown_mod: vector table, directed corner
// sequences, randomized run against a reference model, and a two-digit cascade.
module tb_count_updown_mod;

  localparam int MAXC = 99;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic       enable = 1'b0, up_dn = 1'b1, sync_clear = 1'b0, load = 1'b0;
  logic [6:0] load_value = '0;
  logic [6:0] count_out;
  logic       tc_out, wrap_pulse;
`ifdef COUNT_BCD_EN
  logic [11:0] bcd_out;
  logic [3:0]  c_lo_bcd, c_hi_bcd;
`endif

  logic       c_en = 1'b0;
  logic [3:0] c_lo_cnt, c_hi_cnt;
  logic       c_lo_tc, c_hi_tc, c_lo_wrap, c_hi_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  count_updown_mod dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .enable        (enable),
    .up_dn         (up_dn),
    .sync_clear    (sync_clear),
    .load          (load),
    .load_value    (load_value),
    .count_out     (count_out),
    .tc_out        (tc_out),
    .wrap_pulse    (wrap_pulse)
`ifdef COUNT_BCD_EN
    ,
    .bcd_out       (bcd_out)
`endif
  );

  count_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0), .BCD_DIGITS(1)) u_lo (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .enable        (c_en),
    .up_dn         (1'b1),
    .sync_clear    (1'b0),
    .load          (1'b0),
    .load_value    (4'd0),
    .count_out     (c_lo_cnt),
    .tc_out        (c_lo_tc),
    .wrap_pulse    (c_lo_wrap)
`ifdef COUNT_BCD_EN
    ,
    .bcd_out       (c_lo_bcd)
`endif
  );

  count_updown_mod #(.WIDTH(4), .MAX_COUNT(9), .RESET_VALUE(0), .BCD_DIGITS(1)) u_hi (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .enable        (c_lo_tc),
    .up_dn         (1'b1),
    .sync_clear    (1'b0),
    .load          (1'b0),
    .load_value    (4'd0),
    .count_out     (c_hi_cnt),
    .tc_out        (c_hi_tc),
    .wrap_pulse    (c_hi_wrap)
`ifdef COUNT_BCD_EN
    ,
    .bcd_out       (c_hi_bcd)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int bcd_of(input int v);
    return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Called one time unit after a rising edge; returns at the same phase.
  task automatic tick(input string tag, input bit en, input bit ud, input bit clr,
                      input bit ld, input int lv, input bit e_tc, input int e_cnt,
                      input bit e_wrap);
    enable = en; up_dn = ud; sync_clear = clr; load = ld; load_value = 7'(lv);
    #1;
    chk({tag, "_tc"}, int'(tc_out), int'(e_tc));
    @(posedge clk); #1;
    chk({tag, "_cnt"}, int'(count_out), e_cnt);
    chk({tag, "_wrap"}, int'(wrap_pulse), int'(e_wrap));
`ifdef COUNT_BCD_EN
    chk({tag, "_bcd"}, int'(bcd_out), bcd_of(e_cnt));
`endif
  endtask

  task automatic do_reset();
    enable = 0; up_dn = 1; sync_clear = 0; load = 0; load_value = '0; c_en = 0;
    async_reset_n = 0;
    #1;
    chk("rst_cnt", int'(count_out), 0);
    chk("rst_wrap", int'(wrap_pulse), 0);
    #19;
    async_reset_n = 1;
  endtask

  typedef struct {
    bit en, ud, clr, ld;
    int lv;
    bit e_tc;
    int e_cnt;
    bit e_wrap;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int   m_cnt;
    bit   en, ud, clr, ld, e_tc, e_wrap;
    int   lv;
    int   exp_d[4];

    tbl[0]  = '{1, 0, 1, 1, 50,  0, 0,  0};
    tbl[1]  = '{0, 1, 0, 1, 120, 0, 99, 0};
    tbl[2]  = '{1, 1, 0, 1, 50,  0, 50, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,   0, 51, 0};
    tbl[4]  = '{1, 0, 0, 0, 0,   0, 50, 0};
    tbl[5]  = '{0, 0, 0, 1, 0,   0, 0,  0};
    tbl[6]  = '{1, 0, 0, 0, 0,   1, 99, 1};
    tbl[7]  = '{1, 1, 0, 0, 0,   1, 0,  1};
    tbl[8]  = '{0, 0, 0, 0, 0,   0, 0,  0};
    tbl[9]  = '{1, 1, 0, 1, 99,  0, 99, 0};
    tbl[10] = '{1, 1, 1, 0, 0,   0, 0,  0};
    tbl[11] = '{0, 1, 0, 1, 127, 0, 99, 0};
    tbl[12] = '{1, 0, 0, 0, 0,   0, 98, 0};

    @(posedge clk); #1;
    do_reset();

    // Up-count through a full wrap and a few steps beyond.
    for (int k = 1; k <= 105; k++)
      tick("up", 1, 1, 0, 0, 0, ((k - 1) % 100) == 99, k % 100, (k % 100) == 0);

    // Priority, clamp and wrap vectors from a known zero state.
    do_reset();
    for (int i = 0; i < 13; i++)
      tick($sformatf("vec%0d", i), tbl[i].en, tbl[i].ud, tbl[i].clr, tbl[i].ld,
           tbl[i].lv, tbl[i].e_tc, tbl[i].e_cnt, tbl[i].e_wrap);

    // Down-count wrap from 2.
    exp_d = '{1, 0, 99, 98};
    tick("dn_load", 0, 0, 0, 1, 2, 0, 2, 0);
    for (int i = 0; i < 4; i++)
      tick("dn", 1, 0, 0, 0, 0, i == 2, exp_d[i], i == 2);

    // Hold at 37.
    tick("hold_load", 0, 1, 0, 1, 37, 0, 37, 0);
    for (int i = 0; i < 10; i++)
      tick("hold", 0, 1, 0, 0, 0, 0, 37, 0);

    // Asynchronous reset between edges while counting.
    tick("mid_up", 1, 1, 0, 0, 0, 0, 38, 0);
    enable = 1; up_dn = 0;
    #2 async_reset_n = 0;
    #1;
    chk("async_cnt", int'(count_out), 0);
    chk("async_wrap", int'(wrap_pulse), 0);
    chk("async_tc", int'(tc_out), 1);
    @(posedge clk); #1;
    chk("async_held", int'(count_out), 0);
    async_reset_n = 1;
    tick("post_rst", 1, 1, 0, 0, 0, 0, 1, 0);

    // Reset clears a pending wrap pulse immediately.
    tick("wr_load", 0, 1, 0, 1, 99, 0, 99, 0);
    tick("wr_up", 1, 1, 0, 0, 0, 1, 0, 1);
    enable = 0;
    #3 async_reset_n = 0;
    #1;
    chk("rst_wrap_clr", int'(wrap_pulse), 0);
    @(posedge clk); #1;
    async_reset_n = 1;

`ifdef COUNT_BCD_EN
    tick("bcd7", 0, 1, 0, 1, 7, 0, 7, 0);
    chk("bcd_007", int'(bcd_out), 'h007);
    tick("bcd99", 0, 1, 0, 1, 99, 0, 99, 0);
    chk("bcd_099", int'(bcd_out), 'h099);
`endif

    // Randomized run against the modular-arithmetic reference model.
    do_reset();
    m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      clr = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ud  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0:       lv = 0;
        1:       lv = MAXC;
        default: lv = $urandom_range(0, 127);
      endcase
      e_tc   = en && !clr && !ld && (ud ? (m_cnt == MAXC) : (m_cnt == 0));
      e_wrap = 0;
      if (clr) m_cnt = 0;
      else if (ld) m_cnt = (lv > MAXC) ? MAXC : lv;
      else if (en) begin
        e_wrap = ud ? (m_cnt == MAXC) : (m_cnt == 0);
        m_cnt  = ud ? (m_cnt + 1) % (MAXC + 1) : (m_cnt + MAXC) % (MAXC + 1);
      end
      tick("rnd", en, ud, clr, ld, lv, e_tc, m_cnt, e_wrap);
    end

    // Two-digit cascade: value must equal the number of enabled edges mod 100.
    do_reset();
    c_en = 1;
    for (int k = 1; k <= 157; k++) begin
      @(posedge clk); #1;
      chk("casc_val", int'(c_hi_cnt) * 10 + int'(c_lo_cnt), k % 100);
      if (k == 100) begin
        chk("casc100_hi", int'(c_hi_cnt), 0);
        chk("casc100_lo", int'(c_lo_cnt), 0);
      end
    end
    chk("casc157_hi", int'(c_hi_cnt), 5);
    chk("casc157_lo", int'(c_lo_cnt), 7);
    c_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
